pagerank_serial_reducer: RTL and testbench
==========================================

Name: pagerank_serial_reducer

Overview:
- Reduces the per-thread pre-damp partial rank vectors from the local-update stage into one summed rank per node.
- Emits the sums as a serial node-ordered stream to the damping/convergence compute stage.
- Sits between the per-thread local-update threads and the pagerank compute stage.
- Accumulates one thread contribution per cycle, with valid/ready backpressure on the output.

Parameters:
- NUM_HW_THREADS, 8, number of partitions/threads contributing partial vectors (>=1)
- NODES_IN_GRAPH, 32, number of nodes; length of each partial vector and of the output stream (>=1)

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- nextIteration  input  1  one-cycle pulse from compute stage; clears state for a new iteration
- page_rank_gather  input  [NUM_HW_THREADS][NODES_IN_GRAPH]x64  partial pre-damp ranks, unsigned Q32.32
- done  input  [NUM_HW_THREADS]x1  per-thread gather complete; may be a level or a pulse
- rank_sum  output  64  summed rank for rank_node_id, Q32.32
- rank_node_id  output  32  node index of current output, 0..NODES_IN_GRAPH-1
- rank_valid  output  1  rank_sum/rank_node_id valid
- rank_ready  input  1  downstream accepts; transfer occurs when rank_valid && rank_ready at a rising edge
- stream_start  output  1  one-cycle pulse, coincident with the first cycle rank_valid is high for node 0
- stream_done  output  1  one-cycle pulse, the cycle after the last node's transfer
- busy  output  1  high in REDUCE or EMIT

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0.
  - State WAIT_ALL; sticky done flags cleared; counters and accumulator cleared.
- Sticky done capture:
  - done_seen[t] <= done_seen[t] | done[t] every cycle.
  - Flags are cleared only by reset or nextIteration.
- States:
  - WAIT_ALL:
    - When all done_seen are 1, evaluated on registered flags, go to REDUCE.
    - Set n=0, t=0, acc=0.
  - REDUCE:
    - Each cycle acc <= sat_add(acc, page_rank_gather[t][n]), t++.
    - On t==NUM_HW_THREADS-1: rank_sum <= sat_add(acc, last term), rank_node_id <= n, rank_valid <= 1, go to EMIT.
    - Exactly NUM_HW_THREADS cycles per node.
  - EMIT:
    - Hold rank_sum, rank_node_id and rank_valid stable until a transfer occurs.
    - On transfer with n < NODES_IN_GRAPH-1: rank_valid <= 0, n++, t=0, acc=0, go to REDUCE.
    - On transfer with n == last: rank_valid <= 0, go to FINISH.
  - FINISH:
    - stream_done=1 for one cycle, then go to HOLD.
  - HOLD:
    - No activity until nextIteration.
    - Sticky flags are not re-armed, so no repeated streams.
- stream_start: registered, asserted in the same cycle rank_valid first rises with rank_node_id==0; 0 otherwise.
- Arithmetic:
  - Unsigned 64-bit saturating add: if the carry out is 1, the result is 64'hFFFF_FFFF_FFFF_FFFF.
  - The saturated value persists through the remaining adds for that node.
- Inputs are sampled live. The upstream stage holds page_rank_gather stable from done until nextIteration; this block does not snapshot.
- nextIteration, in any state, takes priority over every other transition:
  - Clear done_seen, rank_valid, stream_start, stream_done, counters and acc.
  - Go to WAIT_ALL.
  - A stream aborted mid-operation produces no stream_done.
- done arriving in the same cycle as nextIteration is dropped (clear wins).
- Latency: first rank_valid is NUM_HW_THREADS+1 cycles after the cycle the last done input is sampled high (1 cycle sticky register + NUM_HW_THREADS REDUCE cycles).
- Throughput: NUM_HW_THREADS+1 cycles per node with rank_ready held at 1.
- rank_ready is ignored when rank_valid=0.

Decomposition:
- pagerank_pkg holds:
  - typedef rank_t (logic [63:0], Q32.32)
  - typedef node_id_t (logic [31:0])
  - RANK_MAX constant
  - function sat_add_rank
  - enum reducer_state_e {WAIT_ALL, REDUCE, EMIT, FINISH, HOLD}
- No sub-module; a single FSM plus datapath.
- Counters sized with $clog2 of the parameters, minimum width 1.

Test Plan:
- Params T=2, N=4. Partial vectors: thread0 = {1.0,2.0,3.0,4.0}, thread1 = {0.5,0.5,0.5,0.5} in Q32.32. done[0] pulses, done[1] pulses 5 cycles later. rank_ready=1. Expected:
  - First rank_valid 3 cycles after done[1] is sampled.
  - Stream ids 0..3 with sums {1.5,2.5,3.5,4.5}.
  - stream_start with id 0.
  - stream_done one cycle after the id 3 transfer.
  - Nothing further until nextIteration.
- Backpressure: rank_ready=0 for 4 cycles while node 1 is valid. Expected:
  - rank_sum and rank_node_id held stable with rank_valid=1.
  - Node 2 appears 3 cycles after rank_ready rises.
- Saturation: thread0[2]=64'hFFFF_FFFF_0000_0000, thread1[2]=64'h0000_0002_0000_0000. Expected: rank_sum for id 2 = 64'hFFFF_FFFF_FFFF_FFFF; other nodes unaffected.
- Abort: nextIteration asserted during EMIT of node 1. Expected:
  - Next cycle rank_valid=0, busy=0, no stream_done.
  - Re-asserting both done restarts the stream at node 0.
- Async reset asserted mid-REDUCE, deasserted between clock edges. Expected:
  - All outputs 0 immediately.
  - State WAIT_ALL; old done flags forgotten.
  - The stream begins only after fresh done on all threads.
- done[0] held high continuously across nextIteration. Expected: flags re-arm the cycle after the clear, and a new stream starts once done[1] also arrives.

Source files
------------

// File: rtl/pagerank_pkg.sv
// Shared types, constants and arithmetic helpers for the PageRank serial reducer.
package pagerank_pkg;

   // Unsigned Q32.32 rank value.
   typedef logic [63:0] rank_t;

   // Node index carried alongside each streamed rank.
   typedef logic [31:0] node_id_t;

   // Saturation ceiling for rank accumulation.
   localparam rank_t RANK_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

   // Reducer control states.
   typedef enum logic [2:0] {
      WAIT_ALL = 3'd0,
      REDUCE   = 3'd1,
      EMIT     = 3'd2,
      FINISH   = 3'd3,
      HOLD     = 3'd4
   } reducer_state_e;

   // Unsigned 64-bit add that clamps to RANK_MAX on carry out. Once the
   // accumulator sits at RANK_MAX, every further add carries (or adds zero),
   // so the saturated value sticks for the rest of the node.
   function automatic rank_t sat_add_rank(input rank_t a, input rank_t b);
      logic [64:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[64] ? RANK_MAX : sum[63:0];
   endfunction

endpackage

// File: rtl/pagerank_serial_reducer.sv
// Sums the per-thread partial rank vectors node by node and streams the
// results, one node at a time, to the damping/convergence stage.
module pagerank_serial_reducer
   import pagerank_pkg::*;
#(
   parameter int NUM_HW_THREADS = 8,
   parameter int NODES_IN_GRAPH = 32
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      nextIteration,
   input  rank_t                     page_rank_gather [NUM_HW_THREADS][NODES_IN_GRAPH],
   input  logic [NUM_HW_THREADS-1:0] done,
   output rank_t                     rank_sum,
   output node_id_t                  rank_node_id,
   output logic                      rank_valid,
   input  logic                      rank_ready,
   output logic                      stream_start,
   output logic                      stream_done,
   output logic                      busy
);

   localparam int TW = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1;
   localparam int NW = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(NUM_HW_THREADS - 1);
   localparam logic [NW-1:0] N_LAST = NW'(NODES_IN_GRAPH - 1);

   reducer_state_e            state_q, state_d;
   logic [NUM_HW_THREADS-1:0] done_seen_q, done_seen_d;
   logic [TW-1:0]             t_q, t_d;
   logic [NW-1:0]             n_q, n_d;
   rank_t                     acc_q, acc_d;
   rank_t                     rank_sum_q, rank_sum_d;
   node_id_t                  rank_node_id_q, rank_node_id_d;
   logic                      rank_valid_q, rank_valid_d;
   logic                      stream_start_q, stream_start_d;
   logic                      stream_done_q, stream_done_d;
   logic                      busy_q, busy_d;

   // Inputs are read live: upstream keeps the partial vectors stable until
   // the next iteration, so no snapshot is taken here.
   rank_t term_s;
   rank_t sum_s;
   assign term_s = page_rank_gather[t_q][n_q];
   assign sum_s  = sat_add_rank(acc_q, term_s);

   // Next-state logic: sticky done capture, FSM transitions and datapath updates.
   always_comb begin
      state_d        = state_q;
      done_seen_d    = done_seen_q | done;
      t_d            = t_q;
      n_d            = n_q;
      acc_d          = acc_q;
      rank_sum_d     = rank_sum_q;
      rank_node_id_d = rank_node_id_q;
      rank_valid_d   = rank_valid_q;
      stream_start_d = 1'b0;
      stream_done_d  = 1'b0;

      if (nextIteration) begin
         // Clear wins over everything, including a done arriving this cycle.
         state_d      = WAIT_ALL;
         done_seen_d  = '0;
         t_d          = '0;
         n_d          = '0;
         acc_d        = '0;
         rank_valid_d = 1'b0;
      end else begin
         case (state_q)
            WAIT_ALL: begin
               if (&done_seen_q) begin
                  state_d = REDUCE;
                  t_d     = '0;
                  n_d     = '0;
                  acc_d   = '0;
               end else begin
                  state_d = WAIT_ALL;
               end
            end
            REDUCE: begin
               if (t_q == T_LAST) begin
                  rank_sum_d     = sum_s;
                  rank_node_id_d = node_id_t'(n_q);
                  rank_valid_d   = 1'b1;
                  stream_start_d = (n_q == '0);
                  state_d        = EMIT;
               end else begin
                  acc_d = sum_s;
                  t_d   = t_q + TW'(1);
               end
            end
            EMIT: begin
               if (rank_ready) begin
                  rank_valid_d = 1'b0;
                  if (n_q == N_LAST) begin
                     stream_done_d = 1'b1;
                     state_d       = FINISH;
                  end else begin
                     n_d     = n_q + NW'(1);
                     t_d     = '0;
                     acc_d   = '0;
                     state_d = REDUCE;
                  end
               end else begin
                  state_d = EMIT;
               end
            end
            FINISH: begin
               state_d = HOLD;
            end
            HOLD: begin
               state_d = HOLD;
            end
            default: begin
               state_d = WAIT_ALL;
            end
         endcase
      end

      busy_d = (state_d == REDUCE) || (state_d == EMIT);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= WAIT_ALL;
         done_seen_q    <= '0;
         t_q            <= '0;
         n_q            <= '0;
         acc_q          <= '0;
         rank_sum_q     <= '0;
         rank_node_id_q <= '0;
         rank_valid_q   <= 1'b0;
         stream_start_q <= 1'b0;
         stream_done_q  <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         done_seen_q    <= done_seen_d;
         t_q            <= t_d;
         n_q            <= n_d;
         acc_q          <= acc_d;
         rank_sum_q     <= rank_sum_d;
         rank_node_id_q <= rank_node_id_d;
         rank_valid_q   <= rank_valid_d;
         stream_start_q <= stream_start_d;
         stream_done_q  <= stream_done_d;
         busy_q         <= busy_d;
      end
   end

   assign rank_sum     = rank_sum_q;
   assign rank_node_id = rank_node_id_q;
   assign rank_valid   = rank_valid_q;
   assign stream_start = stream_start_q;
   assign stream_done  = stream_done_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_pagerank_serial_reducer.sv
// Self-checking bench for pagerank_serial_reducer (2 threads, 4 nodes).
module tb_pagerank_serial_reducer;

   localparam int T = 2;
   localparam int N = 4;
   localparam logic [63:0] MAX = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clock;
   logic        reset_n;
   logic        nextIteration;
   logic [63:0] gather [T][N];
   logic [T-1:0] done;
   logic [63:0] rank_sum;
   logic [31:0] rank_node_id;
   logic        rank_valid;
   logic        rank_ready;
   logic        stream_start;
   logic        stream_done;
   logic        busy;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_sum [N];

   pagerank_serial_reducer #(
      .NUM_HW_THREADS(T),
      .NODES_IN_GRAPH(N)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .nextIteration   (nextIteration),
      .page_rank_gather(gather),
      .done            (done),
      .rank_sum        (rank_sum),
      .rank_node_id    (rank_node_id),
      .rank_valid      (rank_valid),
      .rank_ready      (rank_ready),
      .stream_start    (stream_start),
      .stream_done     (stream_done),
      .busy            (busy)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case the sequence itself stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference: plain wide sum of all thread contributions, clamped to MAX.
   function automatic void compute_expected();
      for (int n = 0; n < N; n++) begin
         logic [66:0] s;
         s = '0;
         for (int t = 0; t < T; t++) s = s + {3'b000, gather[t][n]};
         exp_sum[n] = (s > {3'b000, MAX}) ? MAX : s[63:0];
      end
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_sum"},   rank_sum, 64'd0);
      chk({tag, "_id"},    64'(rank_node_id), 64'd0);
      chk({tag, "_valid"}, 64'(rank_valid), 64'd0);
      chk({tag, "_start"}, 64'(stream_start), 64'd0);
      chk({tag, "_done"},  64'(stream_done), 64'd0);
      chk({tag, "_busy"},  64'(busy), 64'd0);
   endtask

   task automatic pulse_done(input logic [T-1:0] mask);
      done = mask;
      step();
      done = '0;
   endtask

   task automatic next_iter();
      nextIteration = 1'b1;
      step();
      nextIteration = 1'b0;
   endtask

   // Counts cycles until the first rank_valid, called right after the cycle
   // in which the last done was sampled.
   task automatic wait_first_valid(input string tag);
      int lat;
      lat = 0;
      while (rank_valid !== 1'b1 && lat < 50) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(T + 1));
   endtask

   // No stream activity for the given number of cycles.
   task automatic quiet(input string tag, input int cycles);
      int cnt;
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         if (rank_valid || busy || stream_done || stream_start) cnt++;
         step();
      end
      chk({tag, "_quiet"}, 64'(cnt), 64'd0);
   endtask

   // Drives rank_ready and collects one full stream, checking order, sums,
   // start/done pulses, stability under stall and node spacing.
   task automatic collect(input string tag, input int stall_node, input int stall_len, input bit rand_ready);
      int xfers, starts, glitches, stall_left, last_xfer_cyc, done_cyc;
      int first_valid_cyc [N];
      int xfer_cyc [N];
      logic [31:0] got_id [N];
      logic [63:0] got_sum [N];
      bit prev_hold, prev_valid, seen_done, exp_start;
      logic [63:0] prev_sum;
      logic [31:0] prev_id;
      xfers = 0; starts = 0; glitches = 0; stall_left = stall_len;
      last_xfer_cyc = -1; done_cyc = -100;
      prev_hold = 1'b0; prev_valid = 1'b0; seen_done = 1'b0;
      prev_sum = '0; prev_id = '0;
      for (int i = 0; i < N; i++) begin
         first_valid_cyc[i] = -100; xfer_cyc[i] = 0; got_id[i] = '1; got_sum[i] = '0;
      end
      for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
         if (prev_hold && (rank_valid !== 1'b1 || rank_sum !== prev_sum || rank_node_id !== prev_id))
            glitches++;
         if (stream_done === 1'b1) begin
            seen_done = 1'b1;
            done_cyc  = cyc;
         end
         exp_start = rank_valid && !prev_valid && (rank_node_id == 32'd0);
         if (stream_start !== exp_start) glitches++;
         if (stream_start === 1'b1) starts++;
         if (rank_valid && !prev_valid && rank_node_id < N) first_valid_cyc[rank_node_id] = cyc;
         if (rand_ready)
            rank_ready = ($urandom_range(3) != 0);
         else if (rank_valid && rank_node_id == 32'(stall_node) && stall_left > 0) begin
            rank_ready = 1'b0;
            stall_left--;
         end else
            rank_ready = 1'b1;
         prev_hold = rank_valid && !rank_ready;
         if (rank_valid && rank_ready) begin
            if (xfers < N) begin
               got_id[xfers]  = rank_node_id;
               got_sum[xfers] = rank_sum;
            end
            if (rank_node_id < N) xfer_cyc[rank_node_id] = cyc;
            last_xfer_cyc = cyc;
            xfers++;
         end
         prev_valid = rank_valid;
         prev_sum   = rank_sum;
         prev_id    = rank_node_id;
         step();
      end
      rank_ready = 1'b1;
      chk({tag, "_xfers"}, 64'(xfers), 64'(N));
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s_id%0d", tag, i), 64'(got_id[i]), 64'(i));
         chk($sformatf("%s_sum%0d", tag, i), got_sum[i], exp_sum[i]);
      end
      for (int i = 1; i < N; i++)
         chk($sformatf("%s_gap%0d", tag, i), 64'(first_valid_cyc[i] - xfer_cyc[i-1]), 64'(T + 1));
      chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(last_xfer_cyc + 1));
      chk({tag, "_starts"}, 64'(starts), 64'd1);
      chk({tag, "_glitches"}, 64'(glitches), 64'd0);
      if (stall_len > 0) chk({tag, "_stall_used"}, 64'(stall_left), 64'd0);
   endtask

   initial begin
      int k;
      int gap;
      reset_n = 1'b0;
      nextIteration = 1'b0;
      done = '0;
      rank_ready = 1'b1;
      for (int t = 0; t < T; t++)
         for (int n = 0; n < N; n++) gather[t][n] = '0;

      // Reset state.
      #3;
      check_zero("reset");
      step();
      step();
      reset_n = 1'b1;

      // Basic stream: 1,2,3,4 + 0.5 each, done[1] five cycles after done[0].
      for (int n = 0; n < N; n++) begin
         gather[0][n] = 64'(n + 1) << 32;
         gather[1][n] = 64'h0000_0000_8000_0000;
      end
      compute_expected();
      step();
      pulse_done(2'b01);
      repeat (4) step();
      pulse_done(2'b10);
      wait_first_valid("basic");
      collect("basic", -1, 0, 1'b0);
      pulse_done(2'b11);
      quiet("hold", 10);

      // Backpressure on node 1 for four cycles.
      next_iter();
      pulse_done(2'b11);
      wait_first_valid("bp");
      collect("bp", 1, 4, 1'b0);

      // Saturation on node 2.
      gather[0][2] = 64'hFFFF_FFFF_0000_0000;
      gather[1][2] = 64'h0000_0002_0000_0000;
      compute_expected();
      next_iter();
      pulse_done(2'b11);
      wait_first_valid("sat");
      collect("sat", -1, 0, 1'b0);

      // Abort during EMIT of node 1.
      next_iter();
      pulse_done(2'b11);
      k = 0;
      while (!(rank_valid === 1'b1 && rank_node_id == 32'd1) && k < 50) begin
         rank_ready = 1'b1;
         step();
         k++;
      end
      chk("abort_reach_node1", 64'(rank_node_id), 64'd1);
      rank_ready = 1'b0;
      next_iter();
      chk("abort_valid", 64'(rank_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(stream_done), 64'd0);
      rank_ready = 1'b1;
      quiet("abort", 8);
      pulse_done(2'b11);
      wait_first_valid("restart");
      chk("restart_first_id", 64'(rank_node_id), 64'd0);
      collect("restart", -1, 0, 1'b0);

      // Async reset in the middle of REDUCE.
      next_iter();
      pulse_done(2'b11);
      k = 0;
      while (!(busy === 1'b1 && rank_valid === 1'b0) && k < 20) begin
         step();
         k++;
      end
      chk("mid_reduce_busy", 64'(busy), 64'd1);
      #2 reset_n = 1'b0;
      #1 check_zero("async_reset");
      step();
      step();
      #2 reset_n = 1'b1;
      quiet("post_reset", 10);
      pulse_done(2'b01);
      quiet("post_reset_half", 5);
      pulse_done(2'b10);
      wait_first_valid("post_reset");
      collect("post_reset", -1, 0, 1'b0);

      // done[0] held high across nextIteration.
      done = 2'b01;
      step();
      next_iter();
      quiet("held", 6);
      done = 2'b11;
      step();
      done = 2'b01;
      wait_first_valid("held");
      collect("held", -1, 0, 1'b0);
      done = '0;

      // Randomized partial vectors, done ordering and ready pattern.
      for (int it = 0; it < 4; it++) begin
         for (int t = 0; t < T; t++)
            for (int n = 0; n < N; n++)
               gather[t][n] = {$urandom(), $urandom()} >> $urandom_range(40);
         compute_expected();
         next_iter();
         gap = int'($urandom_range(5));
         if ($urandom_range(1) == 0) pulse_done(2'b01); else pulse_done(2'b10);
         repeat (gap) step();
         pulse_done(2'b11);
         wait_first_valid($sformatf("rand%0d", it));
         collect($sformatf("rand%0d", it), -1, 0, 1'b1);
         quiet($sformatf("rand%0d", it), 4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
